// File: rtl/memory_pkg.sv
// Shared helpers for the paged memory: width derivations, read-latency mode names
// and the packed entry-count slice helper.
package memory_pkg;

  localparam string MODE_HIGH_PERF = "HIGH_PERFORMANCE";
  localparam string MODE_LOW_LAT   = "LOW_LATENCY";

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // One extra bit so a completely full page's count is representable.
  function automatic int nent_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int nent_lsb(input int page, input int w);
    return page * w;
  endfunction

endpackage

// File: rtl/memory_paged_cnt.sv
// Entry counter for one page: clear, saturating increment and full flag.
// With MEMORY_PAGED_OVF_EN defined it also keeps a sticky overflow flag.
import memory_pkg::*;

module memory_paged_cnt #(
  parameter int PAGE_DEPTH = 128,
  parameter int NENT_W     = nent_w(PAGE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [NENT_W-1:0] cnt,
`ifdef MEMORY_PAGED_OVF_EN
  output logic              ovf,
`endif
  output logic              full
);

  assign full = (cnt == NENT_W'(PAGE_DEPTH));

  // A clear wins over a same-cycle write, which then lands in entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? NENT_W'(1) : '0;
    end else if (inc && !full) begin
      cnt <= cnt + NENT_W'(1);
    end
  end

`ifdef MEMORY_PAGED_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
    end else if (inc && full) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/memory_paged.sv
// NPAGE append-only pages in one inferred block RAM with internal entry counters
// and a registered read port. Optional overflow reporting: MEMORY_PAGED_OVF_EN.
import memory_pkg::*;

module memory_paged #(
  parameter int    RAM_WIDTH       = 18,
  parameter int    PAGE_DEPTH      = 128,
  parameter int    NPAGE           = 8,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic                                      clka,
  input  logic                                      rsta,
  input  logic                                      wr_en,
  input  logic [clog2(NPAGE)-1:0]                   wr_page,
  input  logic [RAM_WIDTH-1:0]                      wr_data,
  input  logic                                      clr_en,
  input  logic [clog2(NPAGE)-1:0]                   clr_page,
  input  logic                                      rd_en,
  input  logic [clog2(NPAGE)-1:0]                   rd_page,
  input  logic [clog2(PAGE_DEPTH)-1:0]              rd_addr,
  output logic [RAM_WIDTH-1:0]                      dout,
  output logic                                      dout_valid,
`ifdef MEMORY_PAGED_OVF_EN
  output logic [NPAGE-1:0]                          ovf_o,
  output logic [15:0]                               ovf_cnt_o,
`endif
  output logic [NPAGE*nent_w(PAGE_DEPTH)-1:0]       nent_o,
  output logic [NPAGE-1:0]                          full_o
);

  localparam int PAGE_W = clog2(NPAGE);
  localparam int ADDR_W = clog2(PAGE_DEPTH);
  localparam int NENT_W = nent_w(PAGE_DEPTH);
  localparam int DEPTH  = NPAGE * PAGE_DEPTH;

  logic [RAM_WIDTH-1:0] ram [DEPTH];
  logic [NENT_W-1:0]    cnt [NPAGE];
  logic [NPAGE-1:0]     full;
  logic                 clr_hit;
  logic                 wr_ok;
  logic [ADDR_W-1:0]    wr_entry;
  logic [RAM_WIDTH-1:0] ram_q;
  logic                 valid_q;

  assign clr_hit  = clr_en && (clr_page == wr_page);
  assign wr_ok    = wr_en && (clr_hit || !full[wr_page]);
  assign wr_entry = clr_hit ? '0 : cnt[wr_page][ADDR_W-1:0];
  assign full_o   = full;

  for (genvar p = 0; p < NPAGE; p++) begin : g_page
    memory_paged_cnt #(
      .PAGE_DEPTH (PAGE_DEPTH),
      .NENT_W     (NENT_W)
    ) u_cnt (
      .clk  (clka),
      .rst  (rsta),
      .inc  (wr_en && (wr_page == PAGE_W'(p))),
      .clr  (clr_en && (clr_page == PAGE_W'(p))),
      .cnt  (cnt[p]),
`ifdef MEMORY_PAGED_OVF_EN
      .ovf  (ovf_o[p]),
`endif
      .full (full[p])
    );
    assign nent_o[nent_lsb(p, NENT_W) +: NENT_W] = cnt[p];
  end

  always_ff @(posedge clka) begin
    if (wr_ok) begin
      ram[{wr_page, wr_entry}] <= wr_data;
    end
  end

  // Read-first: both the data and the count compare see pre-edge state.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      ram_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_en && ({1'b0, rd_addr} < cnt[rd_page]);
      if (rd_en) begin
        ram_q <= ram[{rd_page, rd_addr}];
      end
    end
  end

  if (RAM_PERFORMANCE == MODE_LOW_LAT) begin : g_low_lat
    assign dout       = ram_q;
    assign dout_valid = valid_q;
  end else begin : g_high_perf
    logic rd_q;

    always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
        rd_q       <= 1'b0;
        dout       <= '0;
        dout_valid <= 1'b0;
      end else begin
        rd_q       <= rd_en;
        dout_valid <= valid_q;
        if (rd_q) begin
          dout <= ram_q;
        end
      end
    end
  end

`ifdef MEMORY_PAGED_OVF_EN
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      ovf_cnt_o <= '0;
    end else if (wr_en && full[wr_page] && !clr_hit && (ovf_cnt_o != 16'hFFFF)) begin
      ovf_cnt_o <= ovf_cnt_o + 16'd1;
    end
  end
`endif

endmodule
